// File: rtl/verin_pkg.sv
// Shared constants for the verin RAM stream writer and the RAM it feeds.
// FSM encodings are plain constants so older tools can reuse them.
package verin_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DEPTH_DEF  = 5120;
    localparam int CNT_W_DEF  = 14;
    localparam int BYTE_LANES = 4;
    localparam int LANE_W     = $clog2(BYTE_LANES);
    localparam int WORD_W     = 8 * BYTE_LANES;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/verin_ram_stream_writer_if.sv
// Byte stream in, RAM s1 write port out, bundled for the writer.
// master is the writer's view; slave is the feeder/RAM side.
interface verin_ram_stream_writer_if
    import verin_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_eop;
    logic              st_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [31:0]       ram_writedata;

    modport master (
        input  st_data, st_valid, st_eop,
        output st_ready,
        output ram_address, ram_byteenable,
        output ram_chipselect, ram_write, ram_writedata
    );

    modport slave (
        output st_data, st_valid, st_eop,
        input  st_ready,
        input  ram_address, ram_byteenable,
        input  ram_chipselect, ram_write, ram_writedata
    );

endinterface

// File: rtl/verin_byte_packer.sv
// Packs accepted bytes little-endian into a word with per-lane enables.
// o_last flags the byte that completes a word or ends the packet.
module verin_byte_packer
    import verin_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_accept,
    input  logic [7:0]            i_data,
    input  logic                  i_eop,
    input  logic                  i_clear,
    output logic [WORD_W-1:0]     o_word,
    output logic [BYTE_LANES-1:0] o_be,
    output logic                  o_last,
    output logic                  o_eop
);

    logic [LANE_W-1:0]     r_lane;
    logic [WORD_W-1:0]     r_word;
    logic [BYTE_LANES-1:0] r_be;
    logic                  r_eop;
    logic                  w_top_lane;

    assign w_top_lane = (r_lane == LANE_W'(BYTE_LANES - 1));
    assign o_last     = i_accept & (w_top_lane | i_eop);
    assign o_word     = r_word;
    assign o_be       = r_be;
    assign o_eop      = r_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_word <= '0;
            r_be   <= '0;
            r_eop  <= 1'b0;
        end else if (i_clear) begin
            r_word <= '0;
            r_be   <= '0;
            r_eop  <= 1'b0;
        end else if (i_accept) begin
            r_word[{r_lane, 3'b000} +: 8] <= i_data;
            r_be[r_lane]                  <= 1'b1;
            r_eop                         <= i_eop;
            r_lane <= o_last ? '0 : r_lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/verin_ram_stream_writer.sv
// Streams bytes into consecutive RAM words from a programmable start
// address, flushing a partial word with reduced enables on end-of-packet.
module verin_ram_stream_writer
    import verin_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    verin_ram_stream_writer_if.master  bus,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           word_count,
    output logic                       wrapped
);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wrapped;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_eop_word;
    logic [WORD_W-1:0]     w_word;
    logic [BYTE_LANES-1:0] w_be;

    assign w_ready  = (r_state == FILL);
    assign w_accept = bus.st_valid & w_ready;

    verin_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_accept (w_accept),
        .i_data   (bus.st_data),
        .i_eop    (bus.st_eop),
        .i_clear  (r_state == WRITE),
        .o_word   (w_word),
        .o_be     (w_be),
        .o_last   (w_last),
        .o_eop    (w_eop_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FILL;
            FILL:    if (w_last) w_next = WRITE;
            WRITE:   w_next = w_eop_word ? DONE : FILL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr    <= (w_next == WRITE);
            r_done  <= (w_next == DONE);
            if (r_state == IDLE && start) begin
                r_addr    <= (int'(start_addr) >= DEPTH) ? '0 : start_addr;
                r_cnt     <= '0;
                r_wrapped <= 1'b0;
                r_busy    <= 1'b1;
            end
            if (r_state == WRITE) begin
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                if (r_addr == ADDR_W'(DEPTH - 1)) begin
                    r_addr    <= '0;
                    r_wrapped <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            if (w_next == DONE) r_busy <= 1'b0;
        end
    end

    // Strobes come from a flop; the bus payload is gated to zero around it.
    assign bus.st_ready       = w_ready;
    assign bus.ram_chipselect = r_wr;
    assign bus.ram_write      = r_wr;
    assign bus.ram_address    = r_wr ? r_addr : '0;
    assign bus.ram_writedata  = r_wr ? w_word : '0;
    assign bus.ram_byteenable = r_wr ? w_be : '0;

    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_cnt;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_verin_ram_stream_writer.sv
// Directed + randomized bench for the verin RAM stream writer.
// Expected RAM writes are derived from the packet bytes by grouping in fours.
module tb_verin_ram_stream_writer;

    localparam int AW = 13;
    localparam int DP = 5120;
    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [CW-1:0] word_count;

    verin_ram_stream_writer_if #(.ADDR_W(AW)) bus ();

    verin_ram_stream_writer #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    logic [7:0]  pkt[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_be[$];
    bit          exp_wrap;
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    logic [3:0]  obs_be[$];

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            n_chk++;
            assert (busy === 1'b0) else begin
                n_fail++;
                $error("FAIL busy_at_done got %b want 0", busy);
            end
        end
        if (bus.ram_write && reset_n) begin
            obs_addr.push_back(int'(bus.ram_address));
            obs_data.push_back(bus.ram_writedata);
            obs_be.push_back(bus.ram_byteenable);
            n_chk++;
            assert (bus.st_ready === 1'b0) else begin
                n_fail++;
                $error("FAIL ready_in_write got %b want 0", bus.st_ready);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.st_ready), 0);
        chk({tag, "_write"}, 32'(bus.ram_write), 0);
        chk({tag, "_cs"}, 32'(bus.ram_chipselect), 0);
        chk({tag, "_addr"}, 32'(bus.ram_address), 0);
        chk({tag, "_data"}, bus.ram_writedata, 0);
        chk({tag, "_be"}, 32'(bus.ram_byteenable), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_count"}, 32'(word_count), 0);
        chk({tag, "_wrapped"}, 32'(wrapped), 0);
    endtask

    // Reference: bytes split into groups of four, one RAM word per group.
    task automatic build_model(input logic [AW-1:0] a0);
        int a;
        a = (int'(a0) >= DP) ? 0 : int'(a0);
        exp_wrap = 0;
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
        for (int i = 0; i < pkt.size(); i += 4) begin
            logic [31:0] w;
            logic [3:0]  b;
            int nb;
            nb = (pkt.size() - i < 4) ? pkt.size() - i : 4;
            w = '0; b = '0;
            for (int k = 0; k < nb; k++) begin
                w[8*k +: 8] = pkt[i+k];
                b[k] = 1'b1;
            end
            exp_addr.push_back(a);
            exp_data.push_back(w);
            exp_be.push_back(b);
            if (a == DP - 1) begin
                a = 0;
                exp_wrap = 1;
            end else begin
                a++;
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers the first n bytes of pkt with random bubbles.
    task automatic drive(input int n, input int bubble_pct, input bit poke);
        int idx, iter;
        bit v, rdy;
        idx = 0; iter = 0;
        while (idx < n && iter < 400) begin
            @(negedge clk);
            v = ($urandom % 100) >= bubble_pct;
            start = poke && (iter == 2);
            start_addr = AW'($urandom);
            bus.st_valid = v;
            bus.st_data = v ? pkt[idx] : 8'($urandom);
            bus.st_eop = v ? (idx == pkt.size() - 1) : 1'($urandom);
            rdy = bus.st_ready;
            @(posedge clk);
            if (v && rdy) idx++;
            iter++;
        end
        chk("drive_budget", 32'(idx), 32'(n));
        @(negedge clk);
        start = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_eop = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input logic [AW-1:0] a,
                           input int bubble_pct, input bit poke);
        int d0;
        obs_addr.delete(); obs_data.delete(); obs_be.delete();
        d0 = n_done;
        pulse_start(a);
        drive(pkt.size(), bubble_pct, poke);
        for (int t = 0; t < 20 && n_done == d0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(n_done - d0), 1);
        build_model(a);
        chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
            chk({tag, "_data"}, obs_data[i], exp_data[i]);
            chk({tag, "_be"}, 32'(obs_be[i]), 32'(exp_be[i]));
        end
        chk({tag, "_count"}, 32'(word_count), 32'(exp_addr.size()));
        chk({tag, "_wrapped"}, 32'(wrapped), 32'(exp_wrap));
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_data = '0;
        bus.st_eop = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_pkt("full", 13'h010, 0, 0);
        chk("full_word0", exp_data[0], 32'h44332211);

        pkt = '{8'hAA, 8'hBB, 8'hCC};
        run_pkt("partial", 13'h020, 0, 0);
        chk("partial_be", exp_be[0], 4'b0111);

        rand_pkt(8);
        run_pkt("wrap", 13'd5119, 0, 0);

        rand_pkt(7);
        run_pkt("bubbles", 13'h100, 50, 0);

        rand_pkt(6);
        run_pkt("ignored_start", 13'h200, 30, 1);

        rand_pkt(5);
        run_pkt("clamp", 13'd6000, 20, 0);

        rand_pkt(4);
        pulse_start(13'h300);
        drive(2, 0, 0);
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("rst_fill");
        @(negedge clk);
        reset_n = 1'b1;
        pkt = '{8'h5A, 8'hC3, 8'h7E};
        run_pkt("after_rst", 13'h040, 0, 0);

        rand_pkt(8);
        pulse_start(13'h050);
        drive(4, 0, 0);
        chk("rst_write_pre", 32'(bus.ram_write), 1);
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("rst_write");
        @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            rand_pkt($urandom_range(1, 12));
            run_pkt("random", AW'($urandom), $urandom_range(0, 60), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
